// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stall vector width, stage indices, write-back channel indices.
package pipe_pkg;

  localparam int unsigned STALL_W = 6;

  // Stage indices into the global stall vector.
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  // Write-back channel indices.
  localparam int unsigned CH_GPR = 0;
  localparam int unsigned CH_HI  = 1;
  localparam int unsigned CH_LO  = 2;
  localparam int unsigned NUM_CH = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk  in  rising-edge clock
//  rst  in  asynchronous active-low reset
//  clr  in  synchronous clear, wins over inc
//  inc  in  increment request; ignored once the count is all-ones
//  cnt  out registered count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid bit plus NCH write-back channels,
// with stall/bubble/flush handling and saturating performance counters.
//  clk        in   rising-edge clock
//  rst        in   asynchronous active-low reset
//  stall      in   global stall vector; bit STAGE is ours, STAGE+1 is downstream
//  flush      in   synchronous clear of this stage, beats any stall
//  in_valid   in   upstream slot holds a real instruction
//  in_we      in   per-channel write enables
//  in_addr    in   per-channel destinations, channel c at [c*AW +: AW]
//  in_data    in   per-channel data, channel c at [c*DW +: DW]
//  out_valid  out  registered valid
//  out_we     out  registered write enables, qualified by valid
//  out_addr   out  registered destinations
//  out_data   out  registered data
//  cnt_clr    in   synchronous clear of both counters
//  stall_cnt  out  cycles with our stall bit set and no flush
//  bubble_cnt out  bubbles inserted
module pipe_stage_reg #(
  parameter int unsigned STALL_W = pipe_pkg::STALL_W,
  parameter int unsigned STAGE   = pipe_pkg::STG_EX,
  parameter int unsigned NCH     = pipe_pkg::NUM_CH,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [NCH-1:0]      in_we,
  input  logic [NCH*AW-1:0]   in_addr,
  input  logic [NCH*DW-1:0]   in_data,
  output logic                out_valid,
  output logic [NCH-1:0]      out_we,
  output logic [NCH*AW-1:0]   out_addr,
  output logic [NCH*DW-1:0]   out_data,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam int unsigned PW = 1 + NCH + NCH * AW + NCH * DW;

  // The downstream stall bit must exist inside the vector.
  if (STAGE + 2 > STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be <= STALL_W-2");
  end

  logic          stg_stall_c;
  logic          dn_stall_c;
  logic          bubble_c;
  logic          stall_inc_c;
  logic          unused_stall;
  logic [PW-1:0] pay_q;
  logic [PW-1:0] pay_d;

  assign stg_stall_c  = stall[STAGE];
  assign dn_stall_c   = stall[STAGE+1];
  // Only two bits of the global vector matter to this stage.
  assign unused_stall = ^stall;

  assign bubble_c    = !flush && stg_stall_c && !dn_stall_c;
  assign stall_inc_c = !flush && stg_stall_c;

  // Register action by priority: flush, load, bubble, hold.
  always_comb begin
    pay_d = pay_q;
    if (flush) begin
      pay_d = '0;
    end else if (!stg_stall_c) begin
      // Invalid loads keep addr/data but never carry a write enable.
      pay_d = {in_valid, in_we & {NCH{in_valid}}, in_addr, in_data};
    end else if (!dn_stall_c) begin
      pay_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pay_q <= '0;
    end else begin
      pay_q <= pay_d;
    end
  end

  assign {out_valid, out_we, out_addr, out_data} = pay_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (stall_inc_c),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (bubble_c),
    .cnt (bubble_cnt)
  );

endmodule
